// File: rtl/conv_mac_arbiter.sv
// Round-robin arbiter sharing one saturating MAC among N requesters, one job in flight.
// Define CONV_MAC_ARB_RELU_EN to clamp negative results to zero on y_data.
module conv_mac_arbiter #(
    parameter int N = 2,
    parameter int W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            req_valid,
    output logic [N-1:0]            req_ready,
    input  logic [N*W-1:0]          req_x,
    input  logic [N*W-1:0]          req_f,
    input  logic [N-1:0]            req_last,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [W-1:0]            y_data,
    output logic [$clog2(N)-1:0]    y_id
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BURST, FLUSH, OUT} state_t;

    state_t               state, state_nxt;
    logic [IW-1:0]        ptr, gnt, pick, idx;
    logic                 any_valid;
    logic signed [W-1:0]  x_g, f_g, p, p_sat, acc, acc_sat, y_res;
    logic signed [2*W-1:0] prod;
    logic signed [W:0]    sum;
    logic                 p_valid, beat_acc;

    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    // First valid requester at or after ptr, wrapping modulo N.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pick      = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = idx;
            end
        end
    end

    assign x_g      = req_x[int'(gnt)*W +: W];
    assign f_g      = req_f[int'(gnt)*W +: W];
    assign beat_acc = (state == BURST) && req_valid[gnt];
    assign prod     = x_g * f_g;
    assign sum      = {acc[W-1], acc} + {p[W-1], p};

    assign p_sat   = (&prod[2*W-1:W-1] || ~|prod[2*W-1:W-1]) ? prod[W-1:0]
                   : (prod[2*W-1] ? MINV : MAXV);
    assign acc_sat = (sum[W] == sum[W-1]) ? sum[W-1:0] : (sum[W] ? MINV : MAXV);

`ifdef CONV_MAC_ARB_RELU_EN
    assign y_res = acc[W-1] ? '0 : acc;
`else
    assign y_res = acc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = BURST;
            BURST:   if (beat_acc && req_last[gnt]) state_nxt = FLUSH;
            FLUSH:   state_nxt = OUT;
            OUT:     if (y_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == BURST) req_ready[gnt] = 1'b1;
        y_valid = (state == OUT);
        y_data  = (state == OUT) ? y_res : '0;
        y_id    = (state == OUT) ? gnt : '0;
    end

    // Product stage registers on the accepted beat; accumulate follows one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            gnt     <= '0;
            p       <= '0;
            p_valid <= 1'b0;
            acc     <= '0;
        end else begin
            p_valid <= beat_acc;
            if (beat_acc) p <= p_sat;
            if (state == IDLE && any_valid) begin
                gnt <= pick;
                ptr <= (pick == IW'(N-1)) ? '0 : pick + 1'b1;
                acc <= '0;
            end else if (p_valid) begin
                acc <= acc_sat;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_arbiter.sv
// Self-checking bench for conv_mac_arbiter: directed scenarios plus randomized jobs
// compared against a job-level reference model.
module tb_conv_mac_arbiter;

    localparam int N = 2;
    localparam int W = 12;
    localparam longint MAXV = (longint'(1) << (W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (W-1));

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_ready, req_last;
    logic [N*W-1:0]   req_x, req_f;
    logic             y_valid, y_ready;
    logic [W-1:0]     y_data;
    logic [0:0]       y_id;

    logic signed [W-1:0] xv [N];
    logic signed [W-1:0] fv [N];

    int total = 0;
    int bad   = 0;
    int bx [16];
    int bf [16];
    int m_ptr = 0;

    conv_mac_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_f(req_f), .req_last(req_last),
        .y_valid(y_valid), .y_ready(y_ready),
        .y_data(y_data), .y_id(y_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_x = '0;
        req_f = '0;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = xv[i];
            req_f[i*W +: W] = fv[i];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sat(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic logic [W-1:0] relu_out(input longint v);
`ifdef CONV_MAC_ARB_RELU_EN
        if (v < 0) return '0;
`endif
        return W'(v);
    endfunction

    // Reference: fold the job's beats through saturating multiply and saturating add.
    function automatic logic [W-1:0] model_job(input int n);
        longint a = 0;
        for (int i = 0; i < n; i++)
            a = sat(a + sat(longint'(bx[i]) * longint'(bf[i])));
        return relu_out(a);
    endfunction

    task automatic model_grant(input logic [N-1:0] mask, output int id);
        id = -1;
        for (int k = 0; k < N; k++) begin
            if (id < 0 && mask[(m_ptr + k) % N]) id = (m_ptr + k) % N;
        end
        if (id >= 0) m_ptr = (id + 1) % N;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        req_last = '0;
        step();
        step();
        reset = 1'b0;
        m_ptr = 0;
    endtask

    // Drives one job for requester r from bx/bf; returns with y_valid seen (or the bound expired).
    task automatic do_job(input int r, input int n, input int bub, output int lat, output bit ok);
        int k = 0;
        int guard = 0;
        bit was;
        xv[r] = W'(bx[0]); fv[r] = W'(bf[0]); req_last[r] = (n == 1);
        req_valid[r] = ($urandom_range(99) >= bub);
        while (k < n && guard < 200) begin
            was = req_ready[r] && req_valid[r];
            step();
            guard++;
            if (was) k++;
            if (k < n) begin
                xv[r] = W'(bx[k]); fv[r] = W'(bf[k]); req_last[r] = (k == n-1);
                req_valid[r] = ($urandom_range(99) >= bub);
            end else begin
                req_valid[r] = 1'b0;
                req_last[r]  = 1'b0;
            end
        end
        ok  = (k == n);
        lat = 1;
        while (!y_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        y_ready = 1'b1;
        xv[0] = '0; xv[1] = '0; fv[0] = '0; fv[1] = '0;
        do_reset();
        total++;
        if (req_ready !== 2'b00 || y_valid !== 1'b0 || y_data !== '0 || y_id !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b yv=%b yd=%0d id=%0d want 0", req_ready, y_valid, y_data, y_id);
        end
    endtask

    task automatic test_basic();
        int lat; bit ok;
        bx[0] = 10; bf[0] = 3; bx[1] = -4; bf[1] = 5; bx[2] = 7; bf[2] = 2;
        do_job(0, 3, 0, lat, ok);
        total++;
        if (!ok || lat != 2) begin
            bad++; $display("FAIL basic_latency got ok=%0d lat=%0d want ok=1 lat=2", ok, lat);
        end
        total++;
        if (y_data !== W'(24) || y_id !== 1'b0) begin
            bad++; $display("FAIL basic_result got %0d id %0d want 24 id 0", $signed(y_data), y_id);
        end
        step();
        total++;
        if (y_valid !== 1'b0) begin
            bad++; $display("FAIL basic_handshake got y_valid=%b want 0", y_valid);
        end
    endtask

    task automatic test_saturation();
        int lat; bit ok;
        bx[0] = 2047; bf[0] = 2047;
        do_job(1, 1, 0, lat, ok);
        total++;
        if (!ok || lat != 2 || y_data !== W'(2047) || y_id !== 1'b1) begin
            bad++; $display("FAIL sat_product got %0d id %0d lat %0d want 2047 id 1 lat 2", $signed(y_data), y_id, lat);
        end
        step();
        bx[1] = 2047; bf[1] = 2047;
        do_job(1, 2, 0, lat, ok);
        total++;
        if (!ok || y_data !== W'(2047) || y_id !== 1'b1) begin
            bad++; $display("FAIL sat_accum got %0d id %0d want 2047 id 1", $signed(y_data), y_id);
        end
        step();
    endtask

    task automatic test_relu();
        int lat; bit ok;
        logic [W-1:0] e;
`ifdef CONV_MAC_ARB_RELU_EN
        e = '0;
`else
        e = W'(-25);
`endif
        bx[0] = -5; bf[0] = 5;
        do_job(0, 1, 0, lat, ok);
        total++;
        if (!ok || y_data !== e || y_id !== 1'b0) begin
            bad++; $display("FAIL relu_result got %0d want %0d", $signed(y_data), $signed(e));
        end
        step();
    endtask

    task automatic test_round_robin();
        int id, cnt;
        logic [W-1:0] e;
        do_reset();
        xv[0] = 3; fv[0] = 4; xv[1] = -2; fv[1] = 6;
        req_last = 2'b11;
        req_valid = 2'b11;
        y_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            model_grant(2'b11, id);
            e = relu_out(sat(longint'(xv[id]) * longint'(fv[id])));
            cnt = 0;
            while (!y_valid && cnt < 20) begin
                step();
                cnt++;
            end
            total++;
            if (y_valid !== 1'b1 || y_id !== 1'(id) || y_data !== e) begin
                bad++;
                $display("FAIL rr_job%0d got yv=%b id=%0d d=%0d want id=%0d d=%0d", j, y_valid, y_id, $signed(y_data), id, $signed(e));
            end
            step();
            total++;
            if (req_ready !== 2'b00 || y_valid !== 1'b0) begin
                bad++; $display("FAIL rr_idle_gap%0d got rdy=%b yv=%b want 00 0", j, req_ready, y_valid);
            end
        end
        req_valid = '0;
        req_last  = '0;
        step();
    endtask

    task automatic test_backpressure();
        int lat, id; bit ok;
        model_grant(2'b11, id);
        xv[1] = 1; fv[1] = 1; req_last[1] = 1'b1; req_valid[1] = 1'b1;
        y_ready = 1'b0;
        bx[0] = 6; bf[0] = 7;
        do_job(0, 1, 0, lat, ok);
        total++;
        if (!ok || lat != 2 || y_data !== W'(42) || y_id !== 1'(id)) begin
            bad++; $display("FAIL bp_first got %0d id %0d lat %0d want 42 id %0d", $signed(y_data), y_id, lat, id);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (y_valid !== 1'b1 || y_data !== W'(42) || y_id !== 1'b0 || req_ready !== 2'b00) begin
                bad++;
                $display("FAIL bp_hold%0d got yv=%b d=%0d id=%0d rdy=%b want 1 42 0 00", c, y_valid, $signed(y_data), y_id, req_ready);
            end
        end
        y_ready = 1'b1;
        step();
        total++;
        if (y_valid !== 1'b0 || req_ready !== 2'b00) begin
            bad++; $display("FAIL bp_no_same_cycle_grant got yv=%b rdy=%b want 0 00", y_valid, req_ready);
        end
        model_grant(2'b10, id);
        step();
        total++;
        if (req_ready !== 2'b10) begin
            bad++; $display("FAIL bp_pending_grant got rdy=%b want 10", req_ready);
        end
        step();
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        step();
        total++;
        if (y_valid !== 1'b1 || y_id !== 1'(id) || y_data !== W'(1)) begin
            bad++; $display("FAIL bp_second got yv=%b id=%0d d=%0d want 1 %0d 1", y_valid, y_id, $signed(y_data), id);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int lat; bit ok;
        xv[1] = 100; fv[1] = 3; req_last[1] = 1'b0; req_valid[1] = 1'b1;
        step();
        step();
        xv[1] = 50; fv[1] = 2;
        step();
        xv[1] = 9; fv[1] = 9; req_last[1] = 1'b1;
        #3 reset = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b00 || y_valid !== 1'b0 || y_data !== '0 || y_id !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got rdy=%b yv=%b d=%0d id=%0d want 0", req_ready, y_valid, y_data, y_id);
        end
        req_valid = '0;
        req_last  = '0;
        step();
        reset = 1'b0;
        m_ptr = 0;
        bx[0] = 4; bf[0] = 6; bx[1] = 5; bf[1] = -1;
        do_job(1, 2, 0, lat, ok);
        total++;
        if (!ok || lat != 2 || y_data !== model_job(2) || y_id !== 1'b1) begin
            bad++; $display("FAIL reset_mid_next got %0d id %0d want %0d id 1", $signed(y_data), y_id, $signed(model_job(2)));
        end
        step();
    endtask

    task automatic test_random();
        int r, n, lat, d; bit ok;
        logic [W-1:0] e;
        for (int j = 0; j < 24; j++) begin
            r = $urandom_range(N-1);
            n = $urandom_range(4, 1);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(3))
                    0:       begin bx[i] = ($urandom_range(1)) ? 2047 : -2048; bf[i] = ($urandom_range(1)) ? 2047 : -2048; end
                    1:       begin bx[i] = int'($urandom_range(4095)) - 2048; bf[i] = int'($urandom_range(4095)) - 2048; end
                    default: begin bx[i] = int'($urandom_range(80)) - 40; bf[i] = int'($urandom_range(80)) - 40; end
                endcase
            end
            e = model_job(n);
            xv[1-r] = W'($urandom); fv[1-r] = W'($urandom); req_last[1-r] = 1'($urandom);
            d = $urandom_range(3);
            y_ready = (d == 0);
            do_job(r, n, 30, lat, ok);
            total++;
            if (!ok || lat != 2 || y_data !== e || y_id !== 1'(r)) begin
                bad++;
                $display("FAIL rand_job%0d got d=%0d id=%0d lat=%0d want d=%0d id=%0d lat=2", j, $signed(y_data), y_id, lat, $signed(e), r);
            end
            repeat (d) step();
            y_ready = 1'b1;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_last  = '0;
        y_ready   = 1'b1;
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
